// File: rtl/dmem_arbiter_if.sv
// Port bundle between the two requesters, the arbiter and the data memory.
// master = requesters plus memory model side, slave = arbiter side.
interface dmem_arbiter_if;
  logic        REQ0;
  logic        REQ1;
  logic        WE0;
  logic        WE1;
  logic [31:0] ADDR0;
  logic [31:0] ADDR1;
  logic [31:0] WDATA0;
  logic [31:0] WDATA1;
  logic [2:0]  SIZE0;
  logic [2:0]  SIZE1;
  logic        GNT0;
  logic        GNT1;
  logic        RVALID0;
  logic        RVALID1;
  logic [31:0] RDATA0;
  logic [31:0] RDATA1;
  logic        ERR0;
  logic        ERR1;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [2:0]  MEM_SIZE;
  logic [31:0] MEM_RDATA;

  modport master (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, SIZE0, SIZE1, MEM_RDATA,
    input  GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, ERR0, ERR1,
           MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE
  );

  modport slave (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, SIZE0, SIZE1, MEM_RDATA,
    output GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, ERR0, ERR1,
           MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter/checker: combinational grant, response 1 cycle later.
// No backpressure on responses; port 1 is forced through after MAX_WAIT refusals.
module dmem_arbiter #(
  parameter int MEMORY_SIZE = 64,
  parameter int MAX_WAIT    = 4
) (
  input logic           CLK,
  input logic           RESET_N,
  dmem_arbiter_if.slave bus
);
  localparam int            WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WCNT_MAX = WW'(MAX_WAIT);
  localparam logic [2:0]    SZ_WORD   = 3'b000;
  localparam logic [2:0]    SZ_BYTE   = 3'b001;
  localparam logic [2:0]    SZ_HALF   = 3'b010;
  localparam logic [2:0]    SZ_BYTE_U = 3'b011;
  localparam logic [2:0]    SZ_HALF_U = 3'b100;

  logic [WW-1:0] wcnt;
  logic          gnt0, gnt1, any_gnt;
  logic          sel_we, illegal;
  logic [31:0]   sel_addr, sel_wdata, resp_data;
  logic [2:0]    sel_size;
  logic [32:0]   nbytes;
  logic          rvalid0_q, rvalid1_q, err0_q, err1_q;
  logic [31:0]   rdata0_q, rdata1_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (RESET_N) begin
      if (bus.REQ0 && bus.REQ1) begin
        gnt1 = (wcnt == WCNT_MAX);
        gnt0 = !gnt1;
      end else begin
        gnt0 = bus.REQ0;
        gnt1 = bus.REQ1;
      end
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel_we    = gnt1 ? bus.WE1    : bus.WE0;
  assign sel_addr  = gnt1 ? bus.ADDR1  : bus.ADDR0;
  assign sel_wdata = gnt1 ? bus.WDATA1 : bus.WDATA0;
  assign sel_size  = gnt1 ? bus.SIZE1  : bus.SIZE0;

  // Range check is done at 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    nbytes  = 33'd0;
    illegal = 1'b0;
    case (sel_size)
      SZ_WORD: begin
        nbytes  = 33'd4;
        illegal = (sel_addr[1:0] != 2'b00);
      end
      SZ_BYTE, SZ_BYTE_U: nbytes = 33'd1;
      SZ_HALF, SZ_HALF_U: begin
        nbytes  = 33'd2;
        illegal = sel_addr[0];
      end
      default: illegal = 1'b1;
    endcase
    if (sel_we && (sel_size == SZ_BYTE_U || sel_size == SZ_HALF_U))
      illegal = 1'b1;
    if (({1'b0, sel_addr} + nbytes) > 33'(MEMORY_SIZE))
      illegal = 1'b1;
  end

  assign resp_data = (!sel_we && !illegal) ? bus.MEM_RDATA : 32'd0;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wcnt      <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
    end else begin
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      if (gnt0) begin
        err0_q   <= illegal;
        rdata0_q <= resp_data;
      end
      if (gnt1) begin
        err1_q   <= illegal;
        rdata1_q <= resp_data;
      end
      if (bus.REQ1 && !gnt1)
        wcnt <= (wcnt == WCNT_MAX) ? wcnt : wcnt + WW'(1);
      else
        wcnt <= '0;
    end
  end

  assign bus.GNT0      = gnt0;
  assign bus.GNT1      = gnt1;
  assign bus.MEM_WE    = any_gnt & sel_we & !illegal;
  assign bus.MEM_ADDR  = sel_addr;
  assign bus.MEM_WDATA = sel_wdata;
  assign bus.MEM_SIZE  = sel_size;
  // Reset in the response cycle squashes the strobe immediately.
  assign bus.RVALID0   = rvalid0_q & RESET_N;
  assign bus.RVALID1   = rvalid1_q & RESET_N;
  assign bus.ERR0      = err0_q;
  assign bus.ERR1      = err1_q;
  assign bus.RDATA0    = rdata0_q;
  assign bus.RDATA1    = rdata1_q;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access checker in front of the byte-addressed data memory. Port 0 serves the pipeline load/store stage. Port 1 serves a debug/DMA loader. The block grants one access per cycle and drives the memory's shared address/data/size/write-enable lines. It rejects misaligned, out-of-range or illegal-size accesses before they reach the array. It returns a registered per-port response one cycle after grant, and a starvation counter guarantees port 1 forward progress under continuous port 0 traffic.

## Interface
- MEMORY_SIZE, 64: bytes in the attached data memory; range-check limit.
- MAX_WAIT, 4: cycles port 1 may be refused while requesting before it is forcibly granted (≥1).
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  synchronous, active-low reset, sampled on rising CLK.
- REQ0 / REQ1  in  1  access request, held with attributes stable until GNTx.
- WE0 / WE1  in  1  1 = store, 0 = load.
- ADDR0 / ADDR1  in  32  byte address.
- WDATA0 / WDATA1  in  32  store data (byte/halfword in low bits).
- SIZE0 / SIZE1  in  3  WORD=000, BYTE=001, HALFWORD=010, BYTE_U=011, HALFWORD_U=100.
- GNT0 / GNT1  out  1  combinational grant this cycle.
- RVALID0 / RVALID1  out  1  registered response strobe, 1 cycle after grant.
- RDATA0 / RDATA1  out  32  registered load data; 0 for stores and errors.
- ERR0 / ERR1  out  1  registered, qualifies RVALIDx; access was rejected.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  32  memory address.
- MEM_WDATA  out  32  memory write data.
- MEM_SIZE  out  3  memory size code.
- MEM_RDATA  in  32  memory combinational read data (already sign/zero-extended by memory).

## Operation
- Arbitration, evaluated every cycle from REQ0, REQ1 and the registered wait counter WCNT:
  - only one REQ high: that port is granted.
  - both high and WCNT < MAX_WAIT: port 0 is granted.
  - both high and WCNT == MAX_WAIT: port 1 is granted.
  - at most one GNT is high in any cycle.
- WCNT:
  - increments when REQ1=1 and GNT1=0, saturating at MAX_WAIT.
  - clears when GNT1=1 or REQ1=0.
  - width is clog2(MAX_WAIT+1).
- Memory outputs:
  - MEM_ADDR/MEM_WDATA/MEM_SIZE follow the granted port's inputs.
  - with no grant they follow port 0, and MEM_WE=0.
- Legality check on the granted access. The access is illegal if any of the following holds:
  - SIZE is 101–111.
  - WE=1 with SIZE BYTE_U or HALFWORD_U.
  - halfword access with ADDR[0]=1.
  - word access with ADDR[1:0]≠00.
  - ADDR+nbytes > MEMORY_SIZE, computed at 33 bits so there is no wrap-around; nbytes is 1/2/4.
- Legal store: MEM_WE=1.
- Illegal access: MEM_WE=0. The memory array is never modified.
- Response, one cycle after grant, on the granted port only:
  - RVALIDx=1.
  - ERRx=1 if the access was illegal.
  - RDATAx = MEM_RDATA captured at the grant edge for a legal load, else 0.
- The non-granted port's RVALID is 0.
- Response registers hold their value until the next grant to that port or reset, but RVALID pulses for exactly one cycle.

## Timing
- Grant and memory drive are combinational in cycle N. Write occurs at the end-of-cycle-N edge. The response is visible in cycle N+1.
- Back-to-back grants to the same port are allowed, giving one access per cycle of throughput.
- The requester may change attributes or drop REQ in cycle N+1. No response-accept handshake exists; the requester must consume RVALID when it pulses.
- While RESET_N=0:
  - GNT0=GNT1=0 and MEM_WE=0.
  - at the edge, WCNT, RVALIDx, ERRx and RDATAx clear to 0.
- A grant in the same cycle as reset is suppressed, with no write and no later response.
- Reset asserted in cycle N+1 of an access clears its pending response.

## Test plan
- Reset then port 0 word store ADDR=8, WDATA=0xDEADBEEF, then word load ADDR=8 → GNT0 each cycle; load gives RVALID0=1, ERR0=0, RDATA0=0xDEADBEEF one cycle after grant.
- Port 1 BYTE load ADDR=9 after the above → RDATA1=0xFFFFFFAD. BYTE_U at the same address → 0x000000AD.
- REQ0 and REQ1 held continuously with MAX_WAIT=4 → GNT0 for 4 cycles, GNT1 in the 5th, then the pattern repeats; GNT0 and GNT1 are never high together.
- Illegal accesses each give MEM_WE=0, ERR=1, RDATA=0, and a later load of the affected bytes shows them unchanged:
  - halfword store at ADDR=3.
  - word load at ADDR=62 (MEMORY_SIZE=64).
  - store with SIZE=HALFWORD_U.
  - load with SIZE=111.
- Word store at ADDR=60 → legal, ERR=0. Word at ADDR=0xFFFFFFFC → ERR=1 with no wrap.
- RESET_N low in the cycle after a granted load → RVALID stays 0. RESET_N low concurrent with REQ0 store → no grant, memory unchanged.
